// File: rtl/fifo_frame_writer_if.sv
// Bundle between the capture-FIFO read side, the frame-buffer write port and frame status.
// master = frame writer (reads FIFO, drives BRAM writes and status); slave = FIFO/BRAM/monitor side.
// Pure wiring; no timing of its own.
interface fifo_frame_writer_if #(
  parameter int ADDR_W = 19
) ();
  logic              fifo_empty;
  logic              fifo_re;
  logic [16:0]       fifo_dout;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [11:0]       bram_din;
  logic              frame_done;
  logic [7:0]        frame_count;
  logic              short_frame;
  logic              overrun;

  modport master (
    input  fifo_empty, fifo_dout,
    output fifo_re, bram_we, bram_addr, bram_din,
           frame_done, frame_count, short_frame, overrun
  );

  modport slave (
    output fifo_empty, fifo_dout,
    input  fifo_re, bram_we, bram_addr, bram_din,
           frame_done, frame_count, short_frame, overrun
  );
endinterface

// File: rtl/fifo_frame_writer.sv
// Drains pixel/marker words from the capture FIFO into a frame buffer as RGB444, aligned to frame markers.
// Latency: 2 cycles from fifo_re to the registered write/pulse; one word per cycle.
// Backpressure: reads whenever the FIFO is non-empty; an empty FIFO simply stalls with state held.
module fifo_frame_writer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19   // 2**ADDR_W must cover H_ACTIVE*V_ACTIVE
) (
  input  logic                   CLK100MHZ,
  input  logic                   reset,
  fifo_frame_writer_if.master    bus
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic {
    SYNC_WAIT = 1'b0,
    ACTIVE    = 1'b1
  } state_t;

  state_t            state;
  logic              first_frame;
  logic [ADDR_W-1:0] wr_ptr;
  logic              rd_valid;

  // RGB565 -> RGB444 keeps the top 4 bits of each channel; the remaining bits are dropped.
  logic unused_pixel_bits;
  assign unused_pixel_bits = ^{bus.fifo_dout[11], bus.fifo_dout[5], bus.fifo_dout[0]};

  // Read as soon as data exists; gated off while reset is held so nothing is popped and lost.
  assign bus.fifo_re = ~bus.fifo_empty & ~reset;

  // Word-handling FSM: rd_valid marks the cycle the FIFO presents the word read one cycle earlier.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state           <= SYNC_WAIT;
      first_frame     <= 1'b1;
      wr_ptr          <= '0;
      rd_valid        <= 1'b0;
      bus.bram_we     <= 1'b0;
      bus.bram_addr   <= '0;
      bus.bram_din    <= '0;
      bus.frame_done  <= 1'b0;
      bus.short_frame <= 1'b0;
      bus.overrun     <= 1'b0;
      bus.frame_count <= '0;
    end else begin
      rd_valid        <= bus.fifo_re;
      bus.bram_we     <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.short_frame <= 1'b0;
      bus.overrun     <= 1'b0;
      if (rd_valid) begin
        if (bus.fifo_dout[16]) begin
          // Marker: start (or restart) a frame at address 0.
          if (state == SYNC_WAIT) begin
            state       <= ACTIVE;
            first_frame <= 1'b0;
          end else if (wr_ptr != '0) begin
            bus.short_frame <= 1'b1;
          end
          wr_ptr <= '0;
        end else if (state == ACTIVE) begin
          bus.bram_we   <= 1'b1;
          bus.bram_addr <= wr_ptr;
          bus.bram_din  <= {bus.fifo_dout[15:12], bus.fifo_dout[10:7], bus.fifo_dout[4:1]};
          if (wr_ptr == LAST_PTR) begin
            bus.frame_done  <= 1'b1;
            bus.frame_count <= bus.frame_count + 8'd1;
            wr_ptr          <= '0;
            state           <= SYNC_WAIT;
          end else begin
            wr_ptr <= wr_ptr + 1'b1;
          end
        end else if (!first_frame) begin
          // Pixel with no frame open; the lead-in before the very first marker is expected.
          bus.overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_frame_writer.sv
// Directed bench for fifo_frame_writer with a 4x2 frame: FIFO model, write log, pulse counters.
// Expected values are hand-computed per test and compared through chk().
// Outputs are sampled on the falling edge.
module tb_fifo_frame_writer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fifo_frame_writer_if #(.ADDR_W(3)) bus ();

  fifo_frame_writer #(
    .H_ACTIVE(4),
    .V_ACTIVE(2),
    .ADDR_W  (3)
  ) dut (
    .CLK100MHZ(clk),
    .reset    (reset),
    .bus      (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO model: registered read data, optional every-other-cycle empty to stall the writer.
  logic [16:0] q[$];
  logic        stall = 1'b0;
  logic        toggle = 1'b0;

  initial begin
    bus.fifo_empty = 1'b1;
    bus.fifo_dout  = '0;
  end

  always @(posedge clk) begin
    if (bus.fifo_re && q.size() > 0) bus.fifo_dout <= q.pop_front();
  end

  always @(negedge clk) begin
    stall          = toggle ? ~stall : 1'b0;
    bus.fifo_empty = (q.size() == 0) | stall;
  end

  // Output monitor: write log plus pulse counters.
  logic [2:0]  wa[$];
  logic [11:0] wd[$];
  int          wc[$];
  int          cyc = 0;
  int          n_fd = 0, n_sf = 0, n_ov = 0;
  logic [2:0]  fd_addr = '0;
  logic        fd_we = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (bus.bram_we) begin
      wa.push_back(bus.bram_addr);
      wd.push_back(bus.bram_din);
      wc.push_back(cyc);
    end
    if (bus.frame_done) begin
      n_fd++;
      fd_addr = bus.bram_addr;
      fd_we   = bus.bram_we;
    end
    if (bus.short_frame) n_sf++;
    if (bus.overrun) n_ov++;
  end

  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete();
    n_fd = 0; n_sf = 0; n_ov = 0;
  endtask

  task automatic push_frame(input logic [15:0] base);
    q.push_back(17'h10000);
    for (int i = 0; i < 8; i++) q.push_back({1'b0, base + 16'(i)});
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain_timeout"}, 32'(n >= 5000), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_fifo_re", bus.fifo_re, 0);
    chk("rst_we", bus.bram_we, 0);
    chk("rst_addr", bus.bram_addr, 0);
    chk("rst_count", bus.frame_count, 0);
    @(negedge clk);
    reset = 1'b0;

    // T1: lead-in pixel, marker, one continuous frame
    clear_log();
    q.push_back(17'h0FFFF);
    push_frame(16'h0000);
    drain("t1");
    chk("t1_nwr", wa.size(), 8);
    for (int i = 0; i < 8 && i < wa.size(); i++) chk("t1_addr", wa[i], i);
    if (wd.size() == 8) begin
      chk("t1_din5", wd[5], 12'h002);
      chk("t1_span", wc[7] - wc[0], 7);
    end
    chk("t1_fd", n_fd, 1);
    chk("t1_fd_addr", fd_addr, 7);
    chk("t1_fd_we", fd_we, 1);
    chk("t1_ov", n_ov, 0);
    chk("t1_count", bus.frame_count, 1);

    // T2: short frame then a full frame
    clear_log();
    q.push_back(17'h10000);
    for (int i = 0; i < 3; i++) q.push_back(17'(i));
    push_frame(16'h0010);
    drain("t2");
    chk("t2_nwr", wa.size(), 11);
    if (wa.size() == 11) begin
      chk("t2_a2", wa[2], 2);
      chk("t2_a3", wa[3], 0);
      chk("t2_a10", wa[10], 7);
    end
    chk("t2_sf", n_sf, 1);
    chk("t2_fd", n_fd, 1);
    chk("t2_count", bus.frame_count, 2);

    // T3: full frame then two stray pixels before the next marker
    clear_log();
    push_frame(16'h0020);
    q.push_back(17'h00123);
    q.push_back(17'h00456);
    drain("t3");
    chk("t3_ov", n_ov, 2);
    chk("t3_nwr", wa.size(), 8);
    chk("t3_count", bus.frame_count, 3);

    // T4: back-to-back markers, magenta pixel, stalled FIFO
    clear_log();
    toggle = 1'b1;
    q.push_back(17'h1ABCD);
    q.push_back(17'h0F81F);
    for (int i = 1; i < 8; i++) q.push_back(17'(i));
    q.push_front(17'h10000);
    drain("t4");
    toggle = 1'b0;
    chk("t4_sf", n_sf, 0);
    chk("t4_nwr", wa.size(), 8);
    for (int i = 0; i < 8 && i < wa.size(); i++) chk("t4_addr", wa[i], i);
    if (wd.size() > 0) chk("t4_magenta", wd[0], 12'hF0F);
    chk("t4_count", bus.frame_count, 4);

    // T5: 252 more frames wrap the 8-bit counter
    clear_log();
    for (int f = 0; f < 252; f++) push_frame(16'(f));
    drain("t5");
    chk("t5_fd", n_fd, 252);
    chk("t5_sf", n_sf, 0);
    chk("t5_count_wrap", bus.frame_count, 0);

    // T6: reset in the middle of a frame
    clear_log();
    push_frame(16'h0040);
    n = 0;
    while (wa.size() < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t6_wait_timeout", 32'(n >= 200), 0);
    #1 reset = 1'b1;
    #1;
    chk("t6_fifo_re", bus.fifo_re, 0);
    chk("t6_we", bus.bram_we, 0);
    chk("t6_addr", bus.bram_addr, 0);
    chk("t6_din", bus.bram_din, 0);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    clear_log();
    q.push_back(17'h0FFFF);
    q.push_back(17'h10000);
    q.push_back(17'h00008);
    drain("t6");
    chk("t6_nwr", wa.size(), 1);
    if (wa.size() > 0) begin
      chk("t6_restart_addr", wa[0], 0);
      chk("t6_restart_din", wd[0], 12'h004);
    end
    chk("t6_ov", n_ov, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
